// File: rtl/alu_pkg.sv
// Shared types for the ALU issue/writeback slice: opcodes, flag bundle and
// register index.
package alu_pkg;

  localparam int NREGS = 4;

  typedef logic [1:0] reg_idx_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_regfile.sv
// 4x4-bit architectural register file: two combinational read ports and one
// write port, cleared by reset.
module alu_regfile
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  reg_idx_t   rd_addr_a,
  output logic [3:0] rd_data_a,
  input  reg_idx_t   rd_addr_b,
  output logic [3:0] rd_data_b,
  input  logic       wr_en,
  input  reg_idx_t   wr_addr,
  input  logic [3:0] wr_data
);

  logic [3:0] mem_reg [NREGS];

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (wr_en && (wr_addr == reg_idx_t'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data_a = mem_reg[rd_addr_a];
  assign rd_data_b = mem_reg[rd_addr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Two-register issue/writeback wrapper around an external combinational ALU,
// with operand forwarding from the instruction leaving EX.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_rd,
  input  logic [1:0]       in_rs1,
  input  logic [1:0]       in_rs2,
  input  logic             in_imm_en,
  input  logic [3:0]       in_imm,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_rd,
  output logic [3:0]       out_result,
  output logic [2:0]       out_flags,
  output logic [CNT_W-1:0] retired
);

  logic       ex_valid_reg;
  logic [3:0] ex_a_reg;
  logic [3:0] ex_b_reg;
  alu_op_e    ex_op_reg;
  reg_idx_t   ex_rd_reg;

  logic       wb_valid_reg;
  reg_idx_t   wb_rd_reg;
  logic [3:0] wb_result_reg;
  alu_flags_t wb_flags_reg;

  logic [CNT_W-1:0] retired_reg;

  logic       ex_adv;
  logic       accept;
  logic       consume;
  logic [3:0] rf_a;
  logic [3:0] rf_b;
  logic [3:0] rs1_val;
  logic [3:0] rs2_val;
  logic [3:0] op_b_next;

  assign ex_adv   = ex_valid_reg && (!wb_valid_reg || out_ready);
  assign in_ready = !ex_valid_reg || ex_adv;
  assign accept   = in_valid && in_ready;
  assign consume  = wb_valid_reg && out_ready;

  // The regfile write of the advancing instruction lands on the same edge as
  // this read, so its result must be bypassed rather than read stale.
  assign rs1_val   = (ex_adv && (ex_rd_reg == in_rs1)) ? alu_result : rf_a;
  assign rs2_val   = (ex_adv && (ex_rd_reg == in_rs2)) ? alu_result : rf_b;
  assign op_b_next = in_imm_en ? in_imm : rs2_val;

  alu_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (in_rs1),
    .rd_data_a (rf_a),
    .rd_addr_b (in_rs2),
    .rd_data_b (rf_b),
    .wr_en     (ex_adv),
    .wr_addr   (ex_rd_reg),
    .wr_data   (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg <= 1'b0;
      ex_a_reg     <= '0;
      ex_b_reg     <= '0;
      ex_op_reg    <= OP_ADD;
      ex_rd_reg    <= '0;
    end else if (accept) begin
      ex_valid_reg <= 1'b1;
      ex_a_reg     <= rs1_val;
      ex_b_reg     <= op_b_next;
      ex_op_reg    <= alu_op_e'(in_op);
      ex_rd_reg    <= in_rd;
    end else if (ex_adv) begin
      ex_valid_reg <= 1'b0;
    end
  end

  // WB payload only changes on a load, keeping out_* stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_reg  <= 1'b0;
      wb_rd_reg     <= '0;
      wb_result_reg <= '0;
      wb_flags_reg  <= '0;
    end else if (ex_adv) begin
      wb_valid_reg  <= 1'b1;
      wb_rd_reg     <= ex_rd_reg;
      wb_result_reg <= alu_result;
      wb_flags_reg  <= '{zero: alu_zero, carry: alu_carry, overflow: alu_overflow};
    end else if (consume) begin
      wb_valid_reg  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_reg <= '0;
    end else if (consume) begin
      retired_reg <= retired_reg + 1'b1;
    end
  end

  assign alu_a      = ex_a_reg;
  assign alu_b      = ex_b_reg;
  assign alu_op     = ex_op_reg;
  assign out_valid  = wb_valid_reg;
  assign out_rd     = wb_rd_reg;
  assign out_result = wb_result_reg;
  assign out_flags  = wb_flags_reg;
  assign retired    = retired_reg;

endmodule
